// File: rtl/fifo_write_ctrl_pkg.sv
// Shared pointer helpers for the async FIFO controllers: Gray conversion and the
// full-compare, written at a fixed maximum width so any pointer size can use them.
package fifo_write_ctrl_pkg;

  localparam int PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full: next write Gray pointer equals the read pointer with its top two bits inverted.
  // The read side reuses this shape with no inversion for its empty compare.
  function automatic logic gray_full(input ptr_max_t gray_next, input ptr_max_t rq,
                                     input int ptr_w);
    return gray_next == (rq ^ (ptr_max_t'(3) << (ptr_w - 2)));
  endfunction

endpackage

// File: rtl/fifo_write_ctrl_sync_ff.sv
// Multi-flop synchroniser for a Gray-coded bus crossing into clk; shared by both
// FIFO domains. No logic ahead of the first flop.
module sync_ff #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-domain controller of the async FIFO: write pointer (binary/Gray), read-pointer
// synchroniser and registered full flag. Define FIFO_WR_LEVEL_EN to build write_level_out.
module fifo_write_ctrl
  import fifo_write_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                 w_clk,
  input  logic                 w_rst_n,
  input  logic                 write_in,
  input  logic [PTR_WIDTH-1:0] read_ptr_gray_in,
  output logic                 write_en_out,
  output logic [PTR_WIDTH-1:0] write_ptr_out,
  output logic [PTR_WIDTH-1:0] write_ptr_gray_out,
  output logic                 full_out,
  output logic [PTR_WIDTH-1:0] write_level_out
);

  logic [PTR_WIDTH-1:0] bin_q;
  logic [PTR_WIDTH-1:0] gray_q;
  logic                 full_q;
  logic [PTR_WIDTH-1:0] bin_next;
  logic [PTR_WIDTH-1:0] gray_next;
  logic [PTR_WIDTH-1:0] rq_sync;
  logic                 accept;
  logic                 full_next;

  sync_ff #(
    .WIDTH       (PTR_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rq_sync (
    .clk   (w_clk),
    .rst_n (w_rst_n),
    .d     (read_ptr_gray_in),
    .q     (rq_sync)
  );

  assign accept    = write_in & ~full_q;
  assign bin_next  = bin_q + PTR_WIDTH'(accept);
  assign gray_next = PTR_WIDTH'(bin2gray(ptr_max_t'(bin_next)));
  // Only the synchronised read pointer is used, so full can only be late to clear.
  assign full_next = gray_full(ptr_max_t'(gray_next), ptr_max_t'(rq_sync), PTR_WIDTH);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      full_q <= full_next;
    end
  end

`ifdef FIFO_WR_LEVEL_EN
  logic [PTR_WIDTH-1:0] rbin_sync;
  logic [PTR_WIDTH-1:0] level_next;
  logic [PTR_WIDTH-1:0] level_q;

  // Stale read pointer makes this an upper bound on occupancy, never an underestimate.
  assign rbin_sync  = PTR_WIDTH'(gray2bin(ptr_max_t'(rq_sync)));
  assign level_next = bin_next - rbin_sync;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) level_q <= '0;
    else          level_q <= level_next;
  end

  assign write_level_out = level_q;
`else
  assign write_level_out = '0;
`endif

  assign write_en_out       = accept;
  assign write_ptr_out      = bin_q;
  assign write_ptr_gray_out = gray_q;
  assign full_out           = full_q;

endmodule
